// File: rtl/enigma_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// enigma_pkg : shared letter constants, crib state and pair types
// Rev 1.0
// ---------------------------------------------------------------
package enigma_pkg;

   localparam int LETTER_W    = 8;
   localparam int NUM_LETTERS = 26;
   localparam int MAX_LETTER  = NUM_LETTERS - 1;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } crib_state_t;

   typedef struct packed {
      logic [LETTER_W-1:0] cipher;
      logic [LETTER_W-1:0] plain;
   } crib_pair_t;

endpackage
`default_nettype wire

// File: rtl/crib_loader_debounce.sv
`default_nettype none
// ---------------------------------------------------------------
// debounce_pulse : stability filter with a 1-cycle rising-edge pulse
// Rev 1.0
// ---------------------------------------------------------------
module debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic resetn,
   input  logic raw,
   output logic level,
   output logic pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_level_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cnt     <= '0;
         level     <= 1'b0;
         r_level_d <= 1'b0;
         pulse     <= 1'b0;
      end else begin
         r_level_d <= level;
         pulse     <= level & ~r_level_d;
         // Any sample agreeing with the filtered level restarts the count
         if (raw == level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= raw;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/crib_loader.sv
`default_nettype none
// ---------------------------------------------------------------
// crib_loader : debounced crib capture and valid/ready stream to the bombe
// Rev 1.0
// ---------------------------------------------------------------
module crib_loader
   import enigma_pkg::*;
#(
   parameter int DEPTH           = 16,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LETTER_W        = 8
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [LETTER_W-1:0]          char_in,
   input  logic                         key_raw,
   input  logic                         go_raw,
   output logic                         crib_valid,
   input  logic                         crib_ready,
   output logic [LETTER_W-1:0]          crib_cipher,
   output logic [LETTER_W-1:0]          crib_plain,
   output logic                         crib_last,
   output logic [$clog2(DEPTH+1)-1:0]   crib_count,
   output logic                         half_pair,
   output logic                         buf_full,
   output logic                         bad_letter,
   output logic                         stream_done
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   crib_state_t         r_state;
   logic [LETTER_W-1:0] r_buf_cipher [DEPTH];
   logic [LETTER_W-1:0] r_buf_plain  [DEPTH];
   logic [LETTER_W-1:0] r_hold;
   logic [PTR_W-1:0]    r_rd_ptr;

   logic                w_key_pulse;
   logic                w_go_pulse;
   logic                w_letter_ok;
   logic                w_can_go;
   logic [PTR_W-1:0]    w_next_ptr;
   logic [CNT_W-1:0]    w_last_idx;

   debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
      .clk    (clk),
      .resetn (resetn),
      .raw    (key_raw),
      .level  (),
      .pulse  (w_key_pulse)
   );

   debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_db (
      .clk    (clk),
      .resetn (resetn),
      .raw    (go_raw),
      .level  (),
      .pulse  (w_go_pulse)
   );

   assign buf_full    = (crib_count == CNT_W'(DEPTH));
   assign w_letter_ok = (char_in <= LETTER_W'(MAX_LETTER));
   assign w_can_go    = (crib_count != '0) && !half_pair;
   assign w_next_ptr  = r_rd_ptr + 1'b1;
   assign w_last_idx  = crib_count - 1'b1;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= LOAD;
         crib_count  <= '0;
         half_pair   <= 1'b0;
         bad_letter  <= 1'b0;
         stream_done <= 1'b0;
         crib_valid  <= 1'b0;
         crib_last   <= 1'b0;
         crib_cipher <= '0;
         crib_plain  <= '0;
         r_rd_ptr    <= '0;
         r_hold      <= '0;
      end else begin
         case (r_state)
            LOAD, DONE: begin
               // Go wins over a simultaneous key; the key pulse is dropped
               if (w_go_pulse && (r_state == DONE || w_can_go)) begin
                  r_state     <= STREAM;
                  r_rd_ptr    <= '0;
                  stream_done <= 1'b0;
                  crib_valid  <= 1'b1;
                  crib_cipher <= r_buf_cipher[0];
                  crib_plain  <= r_buf_plain[0];
                  crib_last   <= (crib_count == CNT_W'(1));
               end else if (w_key_pulse && !w_go_pulse) begin
                  r_state <= LOAD;
                  if (!w_letter_ok) begin
                     bad_letter <= 1'b1;
                  end else if (half_pair) begin
                     r_buf_cipher[crib_count[PTR_W-1:0]] <= r_hold;
                     r_buf_plain[crib_count[PTR_W-1:0]]  <= char_in;
                     crib_count <= crib_count + 1'b1;
                     half_pair  <= 1'b0;
                  end else if (!buf_full) begin
                     r_hold    <= char_in;
                     half_pair <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (crib_ready) begin
                  if (crib_last) begin
                     r_state     <= DONE;
                     crib_valid  <= 1'b0;
                     crib_last   <= 1'b0;
                     stream_done <= 1'b1;
                  end else begin
                     r_rd_ptr    <= w_next_ptr;
                     crib_cipher <= r_buf_cipher[w_next_ptr];
                     crib_plain  <= r_buf_plain[w_next_ptr];
                     crib_last   <= (CNT_W'(w_next_ptr) == w_last_idx);
                  end
               end
            end
            default: r_state <= LOAD;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_crib_loader.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_crib_loader : directed and randomized checks against a pair-queue model
// Rev 1.0
// ---------------------------------------------------------------
module tb_crib_loader;
   import enigma_pkg::*;

   localparam int DEPTH = 4;
   localparam int DB    = 4;
   localparam int LW    = 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [LW-1:0] char_in = '0;
   logic          key_raw = 1'b0;
   logic          go_raw = 1'b0;
   logic          crib_ready = 1'b0;
   logic          crib_valid;
   logic [LW-1:0] crib_cipher;
   logic [LW-1:0] crib_plain;
   logic          crib_last;
   logic [2:0]    crib_count;
   logic          half_pair;
   logic          buf_full;
   logic          bad_letter;
   logic          stream_done;

   int n_checks = 0;
   int n_fails  = 0;

   crib_pair_t    q[$];
   logic          m_half;
   logic          m_bad;
   logic [LW-1:0] m_hold;

   crib_loader #(.DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB), .LETTER_W(LW)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .char_in     (char_in),
      .key_raw     (key_raw),
      .go_raw      (go_raw),
      .crib_valid  (crib_valid),
      .crib_ready  (crib_ready),
      .crib_cipher (crib_cipher),
      .crib_plain  (crib_plain),
      .crib_last   (crib_last),
      .crib_count  (crib_count),
      .half_pair   (half_pair),
      .buf_full    (buf_full),
      .bad_letter  (bad_letter),
      .stream_done (stream_done)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0; key_raw = 1'b0; go_raw = 1'b0; crib_ready = 1'b0;
      tick(); tick();
      resetn = 1'b1;
      q.delete(); m_half = 1'b0; m_bad = 1'b0; m_hold = '0;
      tick();
   endtask

   task automatic model_key(input logic [LW-1:0] c);
      if (c > 8'd25) m_bad = 1'b1;
      else if (m_half) begin
         q.push_back('{cipher: m_hold, plain: c});
         m_half = 1'b0;
      end else if (q.size() < DEPTH) begin
         m_hold = c;
         m_half = 1'b1;
      end
   endtask

   task automatic press_key(input logic [LW-1:0] c);
      char_in = c; key_raw = 1'b1;
      repeat (8) tick();
      key_raw = 1'b0;
      repeat (8) tick();
      model_key(c);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_count"}, 32'(crib_count), 32'(q.size()));
      check({tag, "_half"}, 32'(half_pair), 32'(m_half));
      check({tag, "_full"}, 32'(buf_full), 32'(q.size() == DEPTH));
      check({tag, "_bad"}, 32'(bad_letter), 32'(m_bad));
   endtask

   // Go with ready low so the first pair is parked on the interface
   task automatic press_go(input string tag);
      crib_ready = 1'b0; go_raw = 1'b1;
      repeat (8) tick();
      go_raw = 1'b0;
      repeat (8) tick();
      check({tag, "_go_valid"}, 32'(crib_valid), 32'(q.size() > 0 && !m_half));
   endtask

   // mode 0: ready always high, 1: random ready, 2: 5-cycle stall on second pair
   task automatic run_stream(input string tag, input int mode);
      int ptr = 0;
      int cyc = 0;
      int stall = 0;
      logic r;
      while (ptr < q.size() && cyc < 200) begin
         check({tag, "_valid"}, 32'(crib_valid), 32'd1);
         check({tag, "_cipher"}, 32'(crib_cipher), 32'(q[ptr].cipher));
         check({tag, "_plain"}, 32'(crib_plain), 32'(q[ptr].plain));
         check({tag, "_last"}, 32'(crib_last), 32'(ptr == q.size() - 1));
         if (mode == 0) r = 1'b1;
         else if (mode == 1) r = 1'($urandom_range(0, 1));
         else if (ptr == 1 && stall < 5) begin r = 1'b0; stall++; end
         else r = 1'b1;
         crib_ready = r;
         tick();
         if (r) ptr++;
         cyc++;
      end
      check({tag, "_timeout"}, 32'(cyc < 200), 32'd1);
      crib_ready = 1'b0;
      check({tag, "_end_valid"}, 32'(crib_valid), 32'd0);
      check({tag, "_end_done"}, 32'(stream_done), 32'd1);
      check({tag, "_end_count"}, 32'(crib_count), 32'(q.size()));
   endtask

   initial begin
      do_reset();
      check("rst_valid", 32'(crib_valid), 32'd0);
      check("rst_last", 32'(crib_last), 32'd0);
      check("rst_done", 32'(stream_done), 32'd0);
      check("rst_cipher", 32'(crib_cipher), 32'd0);
      check("rst_plain", 32'(crib_plain), 32'd0);
      check_status("rst");

      // Basic three-pair crib, then a replay from DONE
      press_key(8'd3);  press_key(8'd7);
      press_key(8'd12); press_key(8'd0);
      press_key(8'd25); press_key(8'd4);
      check_status("load3");
      press_go("s1");
      run_stream("s1", 0);
      press_go("replay");
      run_stream("replay", 1);

      // Out-of-range letter rejected, half pair blocks go
      do_reset();
      press_key(8'd26);
      press_key(8'd5);
      check_status("bad");
      check("bad_hold", 32'(m_hold), 32'd5);
      press_go("bad");
      check_status("bad_after_go");

      // Fill to DEPTH, then extra presses are ignored
      press_key(8'd9);
      for (int i = 0; i < 3; i++) begin
         press_key(8'($urandom_range(0, 25)));
         press_key(8'($urandom_range(0, 25)));
      end
      press_key(8'd1);
      press_key(8'd2);
      check_status("full");
      press_go("stall");
      run_stream("stall", 2);

      // Short glitch ignored, long hold gives one capture
      do_reset();
      char_in = 8'd11; key_raw = 1'b1;
      tick(); tick();
      key_raw = 1'b0;
      repeat (10) tick();
      check_status("glitch");
      char_in = 8'd7; key_raw = 1'b1;
      repeat (30) tick();
      key_raw = 1'b0;
      repeat (8) tick();
      model_key(8'd7);
      check_status("longhold");
      press_key(8'd8);
      check_status("longhold_pair");
      press_go("longhold");
      run_stream("longhold", 0);

      // Randomized cribs with random backpressure
      for (int r = 0; r < 6; r++) begin
         int n;
         do_reset();
         n = int'($urandom_range(1, DEPTH));
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) press_key(8'(26 + $urandom_range(0, 229)));
            press_key(8'($urandom_range(0, 25)));
            press_key(8'($urandom_range(0, 25)));
         end
         check_status("rand");
         press_go("rand");
         run_stream("rand", 1);
      end

      // Reset in the middle of a stream
      do_reset();
      press_key(8'd1); press_key(8'd2);
      press_key(8'd3); press_key(8'd4);
      press_key(8'd5); press_key(8'd6);
      press_go("mid");
      crib_ready = 1'b1;
      tick();
      crib_ready = 1'b0;
      check("mid_pair1", 32'(crib_cipher), 32'(q[1].cipher));
      resetn = 1'b0;
      tick();
      check("mid_rst_valid", 32'(crib_valid), 32'd0);
      check("mid_rst_count", 32'(crib_count), 32'd0);
      check("mid_rst_cipher", 32'(crib_cipher), 32'd0);
      resetn = 1'b1;
      q.delete(); m_half = 1'b0; m_bad = 1'b0;
      tick();
      press_go("mid_after");
      check_status("mid_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/crib_loader.md
Name: crib_loader

Overview:
- Upstream feeder for the bombe stage.
- Debounces the raw board key and go inputs, then captures ciphertext/plaintext letter pairs (the crib) from the switch bank into an internal buffer.
- On go, streams the stored pairs to the bombe over a valid/ready handshake, marking the final pair.
- Replaces the raw switch/key wiring into the bombe; exposes counts and flags for HEX/LED display.

Parameters:
- DEPTH, 16, maximum number of crib pairs stored (power of two, 2..32).
- DEBOUNCE_CYCLES, 500000, cycles an input must be stable before it is accepted (10 ms at 50 MHz).
- LETTER_W, 8, width of a letter code.

Ports:
- clk  input  1  system clock (CLOCK_50).
- resetn  input  1  synchronous, active-low reset.
- char_in  input  LETTER_W  letter code from switches; legal range 0..25.
- key_raw  input  1  capture key, active-high, undebounced.
- go_raw  input  1  start key, active-high, undebounced.
- crib_valid  output  1  pair presented to bombe.
- crib_ready  input  1  bombe accepts pair this cycle.
- crib_cipher  output  LETTER_W  ciphertext letter of current pair.
- crib_plain  output  LETTER_W  plaintext letter of current pair.
- crib_last  output  1  current pair is the final stored pair.
- crib_count  output  $clog2(DEPTH+1)  pairs stored.
- half_pair  output  1  cipher letter held, plain letter pending.
- buf_full  output  1  crib_count == DEPTH.
- bad_letter  output  1  sticky: an out-of-range letter was rejected.
- stream_done  output  1  a full stream has completed.

Behaviour:
- Reset (resetn low at clk edge):
  - State goes to LOAD.
  - crib_count = 0; half_pair, bad_letter, stream_done, crib_valid and crib_last = 0.
  - crib_cipher and crib_plain = 0; read pointer = 0; debouncers cleared.
  - Reset is honoured in every state, including mid-stream; the buffer contents are then don't-care.
- Debounce: an input must be stable for DEBOUNCE_CYCLES consecutive cycles before the filtered level changes. A rising edge of the filtered level produces a 1-cycle pulse (key_pulse, go_pulse). Pulse latency is DEBOUNCE_CYCLES+1 cycles from a stable raw input.
- LOAD state, on key_pulse:
  - char_in > 25: pulse is ignored and bad_letter is set. bad_letter is sticky until reset.
  - half_pair = 0 and not buf_full: latch char_in as the cipher letter; set half_pair.
  - half_pair = 1: write {cipher, char_in} at index crib_count; crib_count += 1; clear half_pair. Write takes effect the next cycle.
  - buf_full and half_pair = 0: pulse is ignored.
- LOAD state, on go_pulse:
  - Moves to STREAM only if crib_count > 0 and half_pair = 0; otherwise ignored.
  - On entry, read pointer = 0.
  - key_pulse and go_pulse in the same cycle: go has priority and the key is dropped.
- STREAM state:
  - crib_valid = 1; crib_cipher and crib_plain come from the entry at the read pointer (registered).
  - crib_last = (read pointer == crib_count-1).
  - Outputs hold stable while crib_valid && !crib_ready.
  - Transfer on crib_valid && crib_ready. If not last, read pointer += 1 and the next pair is presented the cycle after. If last, go to DONE.
  - There are no bubbles: back-to-back acceptance gives one pair per cycle.
  - key_pulse and go_pulse are ignored.
- DONE state:
  - crib_valid = 0; stream_done = 1.
  - go_pulse: read pointer = 0, clear stream_done, return to STREAM (replays the same crib).
  - key_pulse: return to LOAD and append, subject to the buf_full rules.
- Buffer is a register array of DEPTH x 2 x LETTER_W (fits in LEs; no RAM inference required).

Decomposition:
- Shared package enigma_pkg:
  - LETTER_W, NUM_LETTERS = 26, MAX_LETTER = 25.
  - crib_state_t enum {LOAD, STREAM, DONE}.
  - crib_pair_t struct {cipher, plain}.
- One sub-module, debounce_pulse: parameter DEBOUNCE_CYCLES; ports clk, resetn, raw, level, pulse. Instantiated twice (key_raw, go_raw).
- The bench overrides DEBOUNCE_CYCLES = 4.

Test Plan:
- Reset, then enter pairs (3,7), (12,0), (25,4) via key pulses, then go. With crib_ready held at 1: three consecutive valid beats (3,7), (12,0), (25,4); crib_last set only on the third; stream_done = 1 one cycle later; crib_count = 3.
- Press key with char_in = 26, then 5: bad_letter = 1 stays set; only 5 is latched (half_pair = 1). Go now is ignored and crib_valid stays 0.
- DEPTH = 4: store 4 pairs, then 2 more presses. buf_full = 1, crib_count stays 4, half_pair stays 0.
- During STREAM, drive crib_ready = 0 for 5 cycles on pair 2. crib_cipher and crib_plain hold pair 2 unchanged; the pointer advances only when ready = 1.
- Raw key glitch of 2 cycles (less than DEBOUNCE_CYCLES): no capture. Stable 4+ cycles: exactly one capture for a long hold.
- Drop resetn mid-STREAM after pair 1: next cycle crib_valid = 0, crib_count = 0, state LOAD. A subsequent go is ignored.
